// File: rtl/spram_fifo_ext.sv
// Synchronous single-clock FIFO. Supports any depth >= 2, standard or FWFT read,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and flush.
module spram_fifo_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("spram_fifo_ext: FIFO_DEPTH must be >= 2");
  end
  if (ADDR_WIDTH != $clog2(FIFO_DEPTH)) begin : g_bad_aw
    $error("spram_fifo_ext: ADDR_WIDTH must equal $clog2(FIFO_DEPTH)");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("spram_fifo_ext: AF_THRESH out of range 1..FIFO_DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("spram_fifo_ext: AE_THRESH out of range 0..FIFO_DEPTH-1");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C     = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C     = (ADDR_WIDTH + 1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   ONE_C    = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  acc_w, acc_r;

  // Acceptance is decided purely from registered flags, so a rejected
  // write (or read) is never rescued by a same-cycle read (or write).
  assign acc_w = wen && !full_q  && !flush;
  assign acc_r = ren && !empty_q && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (acc_w) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      if (acc_r) rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      case ({acc_w, acc_r})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      // A fresh error in the clearing cycle keeps the flag set.
      ovf_d = (ovf_q && !clr_err) || (wen && full_q);
      udf_d = (udf_q && !clr_err) || (ren && empty_q);
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_w) mem[wr_ptr_q] <= wdata;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (acc_r) rdata_d = mem[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end else begin : g_fwft
    // Head entry is exposed directly; forced to zero while empty so reset reads 0.
    assign rdata = empty_q ? '0 : mem[rd_ptr_q];
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_spram_fifo_ext.sv
// Drives a depth-5 standard-mode FIFO and a depth-32 FWFT FIFO with the same
// stimulus and compares both against queue-based reference models.
module tb_spram_fifo_ext;

  logic       clk, rst, flush, wen, ren, clr_err;
  logic [7:0] wdata;

  logic       full5, af5, empty5, ae5, ovf5, udf5;
  logic [7:0] rdata5;
  logic [3:0] count5;

  logic       full32, af32, empty32, ae32, ovf32, udf32;
  logic [7:0] rdata32;
  logic [5:0] count32;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] q5[$], q32[$];
  bit         ovf5m, udf5m, ovf32m, udf32m;
  logic [7:0] rd5m, rd32m;

  spram_fifo_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_d5 (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata), .full(full5),
    .almost_full(af5), .ren(ren), .rdata(rdata5), .empty(empty5), .almost_empty(ae5),
    .count(count5), .overflow(ovf5), .underflow(udf5), .clr_err(clr_err));

  spram_fifo_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .FWFT(1)) u_d32 (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata), .full(full32),
    .almost_full(af32), .ren(ren), .rdata(rdata32), .empty(empty32), .almost_empty(ae32),
    .count(count32), .overflow(ovf32), .underflow(udf32), .clr_err(clr_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of the reference: rules taken from the acceptance/flag definitions.
  task automatic mstep(input int depth, inout logic [7:0] q[$], inout bit ovf,
                       inout bit udf, inout logic [7:0] rd);
    bit was_full, was_empty;
    was_full  = (q.size() == depth);
    was_empty = (q.size() == 0);
    if (flush) begin
      q.delete();
      ovf = 1'b0;
      udf = 1'b0;
    end else begin
      if (ren && !was_empty) rd = q.pop_front();
      if (wen && !was_full)  q.push_back(wdata);
      ovf = (ovf && !clr_err) || (wen && was_full);
      udf = (udf && !clr_err) || (ren && was_empty);
    end
  endtask

  task automatic check_dut(input string p, input int depth, input int af, input int ae,
                           input bit fwft, input logic [7:0] q[$], input bit ovf, input bit udf,
                           input logic [7:0] rd, input int a_cnt, input int a_full, input int a_af,
                           input int a_empty, input int a_ae, input int a_ovf, input int a_udf,
                           input int a_rd);
    int n;
    n = q.size();
    chk({p, "count"},        a_cnt,   n);
    chk({p, "full"},         a_full,  int'(n == depth));
    chk({p, "empty"},        a_empty, int'(n == 0));
    chk({p, "almost_full"},  a_af,    int'(n >= af));
    chk({p, "almost_empty"}, a_ae,    int'(n <= ae));
    chk({p, "overflow"},     a_ovf,   int'(ovf));
    chk({p, "underflow"},    a_udf,   int'(udf));
    if (!fwft)       chk({p, "rdata"}, a_rd, int'(rd));
    else if (n != 0) chk({p, "rdata"}, a_rd, int'(q[0]));
  endtask

  task automatic check_all();
    check_dut("d5_", 5, 3, 1, 1'b0, q5, ovf5m, udf5m, rd5m, int'(count5), int'(full5),
              int'(af5), int'(empty5), int'(ae5), int'(ovf5), int'(udf5), int'(rdata5));
    check_dut("d32_", 32, 30, 2, 1'b1, q32, ovf32m, udf32m, rd32m, int'(count32), int'(full32),
              int'(af32), int'(empty32), int'(ae32), int'(ovf32), int'(udf32), int'(rdata32));
  endtask

  task automatic cyc(input bit f, input bit w, input logic [7:0] wd, input bit r, input bit ce);
    flush = f; wen = w; wdata = wd; ren = r; clr_err = ce;
    @(posedge clk);
    #1;
    mstep(5,  q5,  ovf5m,  udf5m,  rd5m);
    mstep(32, q32, ovf32m, udf32m, rd32m);
    check_all();
  endtask

  task automatic model_reset();
    q5.delete();
    q32.delete();
    ovf5m = 0; udf5m = 0; ovf32m = 0; udf32m = 0;
    rd5m = '0; rd32m = '0;
  endtask

  // Checked against fixed reset values, not the model, so a broken reset shows up directly.
  task automatic check_reset(input string p);
    chk({p, "d5_count"},  int'(count5),  0);
    chk({p, "d5_full"},   int'(full5),   0);
    chk({p, "d5_af"},     int'(af5),     0);
    chk({p, "d5_empty"},  int'(empty5),  1);
    chk({p, "d5_ae"},     int'(ae5),     1);
    chk({p, "d5_ovf"},    int'(ovf5),    0);
    chk({p, "d5_udf"},    int'(udf5),    0);
    chk({p, "d5_rdata"},  int'(rdata5),  0);
    chk({p, "d32_count"}, int'(count32), 0);
    chk({p, "d32_full"},  int'(full32),  0);
    chk({p, "d32_af"},    int'(af32),    0);
    chk({p, "d32_empty"}, int'(empty32), 1);
    chk({p, "d32_ae"},    int'(ae32),    1);
    chk({p, "d32_ovf"},   int'(ovf32),   0);
    chk({p, "d32_udf"},   int'(udf32),   0);
  endtask

  task automatic rand_phase(input int ncyc, input int pw, input int pr);
    for (int i = 0; i < ncyc; i++)
      cyc(($urandom_range(99) < 2), ($urandom_range(99) < pw), 8'($urandom()),
          ($urandom_range(99) < pr), ($urandom_range(99) < 5));
  endtask

  initial begin
    rst = 1'b1; flush = 0; wen = 0; ren = 0; clr_err = 0; wdata = '0;
    model_reset();
    #2;
    check_reset("por_");
    @(negedge clk);
    rst = 1'b0;

    // 1: fill depth-5 then drain in order
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(10 + i), 0, 0);
    chk("t1_full", int'(full5), 1);
    chk("t1_count", int'(count5), 5);
    chk("t1_af", int'(af5), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("t1_rdata", int'(rdata5), 10 + i);
    end
    chk("t1_empty", int'(empty5), 1);

    // 2: pointer wrap on the non-power-of-two depth
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(20 + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(30 + i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("t2_rdata", int'(rdata5), 30 + i);
    end

    // 3: write while full with a concurrent read, then clr_err behaviour
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(40 + i), 0, 0);
    cyc(0, 1, 99, 1, 0);
    chk("t3_ovf", int'(ovf5), 1);
    chk("t3_count", int'(count5), 4);
    chk("t3_rdata", int'(rdata5), 40);
    cyc(0, 0, 0, 0, 1);
    chk("t3_clr", int'(ovf5), 0);
    cyc(0, 1, 45, 0, 0);
    cyc(0, 1, 99, 0, 1);
    chk("t3_setwins", int'(ovf5), 1);

    // 4: read while empty, then write+read on empty
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t4_udf", int'(udf5), 1);
    chk("t4_rdata_hold", int'(rdata5), 40);
    cyc(0, 1, 22, 1, 0);
    chk("t4_count", int'(count5), 1);
    chk("t4_udf2", int'(udf5), 1);

    // 5: FWFT behaviour on the depth-32 instance
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 65, 0, 0);
    chk("t5_empty", int'(empty32), 0);
    chk("t5_rdata", int'(rdata32), 65);
    cyc(0, 0, 0, 1, 0);
    chk("t5_empty2", int'(empty32), 1);
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 1, 8'(i), 1, 0);
      chk("t5_count", int'(count32), 1);
      chk("t5_head", int'(rdata32), i);
    end

    // 6: flush beats a same-cycle write and clears errors
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(50 + i), 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("t6_pre_count", int'(count5), 4);
    cyc(1, 1, 77, 0, 0);
    chk("t6_count", int'(count5), 0);
    chk("t6_empty", int'(empty5), 1);
    chk("t6_ovf", int'(ovf5), 0);

    // Random traffic, with an asynchronous reset dropped in between edges
    rand_phase(150, 60, 50);
    rand_phase(120, 90, 20);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset("arst_");
    flush = 0; wen = 0; ren = 0; clr_err = 0;
    @(negedge clk);
    rst = 1'b0;
    rand_phase(120, 90, 25);
    rand_phase(150, 40, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
